// File: rtl/alu_issue.sv
// In-order issue unit for the 4-stage ALU with RAW hazard bubbles.
// Optional HAZ_OPMASK_EN: compare only the source fields func reads.
module alu_issue #(
  parameter int DEPTH   = 16,
  parameter int HAZ_WIN = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int DW = $clog2(HAZ_WIN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [23:0]   ld_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          issue_valid,
  output logic [3:0]    issue_func,
  output logic [3:0]    issue_rd,
  output logic [3:0]    issue_rs1,
  output logic [3:0]    issue_rs2,
  output logic [7:0]    issue_addr,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [23:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_pc;
  logic [AW:0]     r_len;
  logic [DW-1:0]   r_drain;
  logic [HAZ_WIN-1:0] r_hv;
  logic [3:0]      r_hrd [HAZ_WIN];
  logic            r_busy;
  logic            r_done;
  logic            r_iv;
  logic [23:0]     r_iw;
  logic [15:0]     r_stall;

  logic [23:0]     w_word;
  logic [3:0]      w_func;
  logic [3:0]      w_rs1;
  logic [3:0]      w_rs2;
  logic            w_use1;
  logic            w_use2;
  logic            w_hazard;
  logic            w_fire;
  logic            w_last;
  logic            w_start;
  logic [AW:0]     w_len_in;
  logic            w_busy_nx;
  logic            w_done_nx;

  assign w_word   = r_mem[r_pc];
  assign w_func   = w_word[23:20];
  assign w_rs1    = w_word[15:12];
  assign w_rs2    = w_word[11:8];
  assign w_start  = start && (r_state == S_IDLE);
  assign w_len_in = (prog_len > (AW+1)'(DEPTH)) ?
                    (AW+1)'(DEPTH) : prog_len;
  assign w_last   = ({1'b0, r_pc} == (r_len - 1'b1));
  assign w_fire   = (r_state == S_RUN) && !w_hazard;

  always_comb begin
`ifdef HAZ_OPMASK_EN
    w_use1 = !(w_func == 4'd4 || w_func == 4'd9);
    w_use2 = !(w_func == 4'd3 || w_func == 4'd8 ||
               w_func == 4'd10 || w_func == 4'd11);
`else
    w_use1 = 1'b1;
    w_use2 = 1'b1;
`endif
  end

  // Entries are older issue slots only, so self-dependency never matches.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) begin
      if (r_hv[i] &&
          ((w_use1 && r_hrd[i] == w_rs1) ||
           (w_use2 && r_hrd[i] == w_rs2)))
        w_hazard = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_en && !r_busy)
      r_mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_start)
          w_next = (w_len_in == '0) ? S_DONE : S_RUN;
      S_RUN:
        if (w_fire && w_last) w_next = S_DRAIN;
      S_DRAIN:
        if (r_drain == DW'(HAZ_WIN - 1)) w_next = S_DONE;
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nx = (w_next == S_RUN) || (w_next == S_DRAIN);
    w_done_nx = (w_next == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_len   <= '0;
      r_drain <= '0;
      r_hv    <= '0;
      for (int i = 0; i < HAZ_WIN; i++)
        r_hrd[i] <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_iv    <= 1'b0;
      r_iw    <= '0;
      r_stall <= '0;
    end else begin
      r_busy <= w_busy_nx;
      r_done <= w_done_nx;
      r_iv   <= w_fire;
      if (r_state == S_DRAIN) r_drain <= r_drain + 1'b1;
      else                    r_drain <= '0;
      if (w_start) begin
        r_len   <= w_len_in;
        r_pc    <= '0;
        r_stall <= '0;
        r_hv    <= '0;
      end
      if (r_state == S_RUN) begin
        for (int i = HAZ_WIN - 1; i > 0; i--) begin
          r_hv[i]  <= r_hv[i-1];
          r_hrd[i] <= r_hrd[i-1];
        end
        r_hv[0]  <= w_fire;
        r_hrd[0] <= w_word[19:16];
        if (w_fire) begin
          r_iw <= w_word;
          if (!w_last) r_pc <= r_pc + 1'b1;
        end else if (r_stall != 16'hFFFF) begin
          r_stall <= r_stall + 16'd1;
        end
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign issue_valid = r_iv;
  assign issue_func  = r_iw[23:20];
  assign issue_rd    = r_iw[19:16];
  assign issue_rs1   = r_iw[15:12];
  assign issue_rs2   = r_iw[11:8];
  assign issue_addr  = r_iw[7:0];
  assign stall_cnt   = r_stall;

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Instruction issue unit that drives the operand/opcode fields of the 4-stage pipelined ALU: rs1, rs2, rd, func and addr.
- Holds a small program buffer that is loaded word-by-word, then issued in order, at most one instruction per cycle, once start is given.
- Detects read-after-write hazards against instructions still in flight before register-bank writeback, and inserts bubbles (issue_valid=0) until they clear.
- It is the producer end of the ALU's instruction interface.

Parameters:
- DEPTH, 16, program buffer entries (power of 2); AW = log2(DEPTH).
- HAZ_WIN, 2, number of issue slots after a producer during which its rd is not yet readable from the register bank.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_en  in  1  write ld_data into buffer[ld_addr]; ignored while busy=1.
- ld_addr  in  AW  buffer write index.
- ld_data  in  24  instruction word: [23:20] func, [19:16] rd, [15:12] rs1, [11:8] rs2, [7:0] addr.
- prog_len  in  AW+1  number of instructions to issue (0..DEPTH); sampled on accepted start.
- start  in  1  begin issue from buffer[0]; accepted only in IDLE.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the program has fully drained.
- issue_valid  out  1  issue fields carry a real instruction this cycle.
- issue_func  out  4  to ALU func.
- issue_rd  out  4  to ALU rd.
- issue_rs1  out  4  to ALU rs1.
- issue_rs2  out  4  to ALU rs2.
- issue_addr  out  8  to ALU addr.
- stall_cnt  out  16  bubbles inserted for hazards since last accepted start; saturates at 16'hFFFF.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; pc=0.
  - busy, done, issue_valid = 0; all issue_* fields = 0; stall_cnt=0.
  - Hazard history cleared to invalid.
  - Buffer contents are not reset. A reset mid-RUN aborts issue immediately, with no done pulse.
- FSM:
  - IDLE: on start, sample prog_len into len and clear stall_cnt.
    - len=0: go to DONE.
    - len>0: go to RUN with pc=0.
  - RUN: each cycle, evaluate buffer[pc].
    - No hazard: register its fields onto issue_* with issue_valid=1 in the next cycle; pc++.
    - After issuing index len-1, go to DRAIN.
  - DRAIN: wait HAZ_WIN cycles with issue_valid=0, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start in any state other than IDLE is ignored.
- Outputs are registered. When issue_valid=0, the issue_* fields hold their last values.
- Hazard history: HAZ_WIN-deep shift register of {valid, rd}, shifted every RUN cycle.
  - An issued instruction enters as valid; a bubble enters as invalid.
  - Hazard = any valid history entry whose rd equals a compared source field of buffer[pc] (see Optional Feature).
  - On hazard: bubble issued, pc holds, stall_cnt += 1 (saturating).
- Spacing: a consumer issues no earlier than HAZ_WIN+1 cycles after its producer. With HAZ_WIN=2 a back-to-back dependency yields the issue_valid pattern 1,0,0,1.
- An instruction whose rd equals its own rs1/rs2 is not a hazard against itself. History is compared only with previously issued entries.
- func 12..15 are issued unchanged; for hazard purposes they are treated as using both rs1 and rs2.
- ld_en while busy=1 has no effect. ld_en in the same cycle as an accepted start writes the buffer; the issue then sees the new word.
- pc never exceeds len-1. If prog_len > DEPTH it is clamped to DEPTH.

Optional Feature:
- Macro: HAZ_OPMASK_EN.
- Defined: compare only the operands func actually reads.
  - rs1 only: func 3, 8, 10, 11.
  - rs2 only: func 4, 9.
  - Both: func 0-2, 5-7, 12-15.
- Undefined: always compare both rs1 and rs2, regardless of func.

Test Plan:
- Reset mid-RUN (assert rst_n=0 at third issue) -> busy=0, issue_valid=0, stall_cnt=0 immediately; no done pulse; restarting start reissues from buffer[0].
- Load 4 independent words (distinct rd, sources not matching any rd), prog_len=4, start -> issue_valid 1,1,1,1 on consecutive cycles, in buffer order; done pulses 2 cycles after the last issue; stall_cnt=0.
- I0 {func0, rd5, rs1=1, rs2=2}, I1 {func0, rd6, rs1=5, rs2=3} -> issue_valid 1,0,0,1; stall_cnt=2.
- I0 rd=7, I1 {func3, rd8, rs1=1, rs2=7} -> with HAZ_OPMASK_EN: 1,1 and stall_cnt=0; without it: 1,0,0,1 and stall_cnt=2.
- prog_len=0, start -> no issue_valid; done=1 one cycle after start; busy stays 0.
- start and ld_en pulsed while busy -> ignored; buffer unchanged; run completes with the original program.
